inst_mem_stage: RTL and testbench

- Memory-access stage of the 5-stage core, between the execute stage (ex2mem_*) and the write-back stage.
- Issues loads and stores to the data bus using a req/gnt/rvalid handshake.
- Aligns and sign/zero-extends load data, and flags misaligned accesses as exceptions.
- Registers all results into the mem2wb_*_ffout pipeline registers that write-back consumes.
- Stalls upstream while a bus access is outstanding.

---
 rtl/inst_mem_stage.sv | 194 +++++++++++++++++++
 tb/tb_inst_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_stage.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid data bus,
// aligns load data and registers results into the mem2wb pipeline registers.
module inst_mem_stage #(
    parameter int AW   = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex2mem_valid,
    input  logic            ex2mem_memrd,
    input  logic            ex2mem_memwr,
    input  logic [2:0]      ex2mem_funct3,
    input  logic [AW-1:0]   ex2mem_memaddr,
    input  logic [XLEN-1:0] ex2mem_memwdata,
    input  logic            ex2mem_wr_reg,
    input  logic [4:0]      ex2mem_wr_regindex,
    input  logic [XLEN-1:0] ex2mem_wr_wdata,
    input  logic            ex2mem_wr_csrreg,
    input  logic [11:0]     ex2mem_wr_csrindex,
    input  logic [XLEN-1:0] ex2mem_wr_csrwdata,
    input  logic            ex2mem_exp,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [AW-1:0]   dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic            mem_stall,
    output logic            mem2wb_wr_reg_ffout,
    output logic [4:0]      mem2wb_wr_regindex_ffout,
    output logic [XLEN-1:0] mem2wb_wr_wdata_ffout,
    output logic            mem2wb_rd_is_x1_ffout,
    output logic            mem2wb_rd_is_xn_ffout,
    output logic            mem2wb_wr_csrreg_ffout,
    output logic [11:0]     mem2wb_wr_csrindex_ffout,
    output logic [XLEN-1:0] mem2wb_wr_csrwdata_ffout,
    output logic            mem2wb_exp_ffout
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      off;
    logic            is_mem, misaligned, legal_mem, complete;
    logic [3:0]      store_be;
    logic [XLEN-1:0] store_wdata, shifted, load_data;

    logic            wr_reg_d, wr_reg_q;
    logic [4:0]      wr_regindex_d, wr_regindex_q;
    logic [XLEN-1:0] wr_wdata_d, wr_wdata_q;
    logic            rd_is_x1_d, rd_is_x1_q;
    logic            rd_is_xn_d, rd_is_xn_q;
    logic            wr_csrreg_d, wr_csrreg_q;
    logic [11:0]     wr_csrindex_d, wr_csrindex_q;
    logic [XLEN-1:0] wr_csrwdata_d, wr_csrwdata_q;
    logic            exp_d, exp_q;

    always_comb begin
        off    = ex2mem_memaddr[1:0];
        is_mem = ex2mem_valid & (ex2mem_memrd | ex2mem_memwr);
        case (ex2mem_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        legal_mem = is_mem & ~ex2mem_exp & ~misaligned;
    end

    always_comb begin
        store_be    = 4'b1111;
        store_wdata = ex2mem_memwdata;
        case (ex2mem_funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << off;
                store_wdata = {4{ex2mem_memwdata[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << off;
                store_wdata = {2{ex2mem_memwdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = dbus_rdata >> {off, 3'b000};
        case (ex2mem_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Bus fields come straight from ex2mem_*, which upstream holds while stalled.
    always_comb begin
        state_d   = state_q;
        dbus_req  = 1'b0;
        mem_stall = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: if (legal_mem) begin
                dbus_req  = 1'b1;
                mem_stall = 1'b1;
                state_d   = dbus_gnt ? WAIT : REQ;
            end
            REQ: begin
                dbus_req  = 1'b1;
                mem_stall = 1'b1;
                if (dbus_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (dbus_rvalid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            dbus_req  = 1'b0;
            mem_stall = 1'b0;
        end
        dbus_we    = dbus_req & ex2mem_memwr;
        dbus_be    = dbus_req ? (ex2mem_memwr ? store_be : 4'b1111) : 4'b0000;
        dbus_addr  = {ex2mem_memaddr[AW-1:2], 2'b00};
        dbus_wdata = store_wdata;
    end

    always_comb begin
        wr_regindex_d = ex2mem_wr_regindex;
        wr_wdata_d    = (complete & ~ex2mem_memwr) ? load_data : ex2mem_wr_wdata;
        rd_is_x1_d    = (ex2mem_wr_regindex == 5'd1);
        rd_is_xn_d    = (ex2mem_wr_regindex != 5'd0);
        wr_csrindex_d = ex2mem_wr_csrindex;
        wr_csrwdata_d = ex2mem_wr_csrwdata;
        wr_reg_d      = 1'b0;
        wr_csrreg_d   = 1'b0;
        exp_d         = 1'b0;
        if (complete) begin
            wr_reg_d    = ex2mem_wr_reg & ~ex2mem_memwr;
            wr_csrreg_d = ex2mem_wr_csrreg;
        end else if (state_q == IDLE && ex2mem_valid && !legal_mem) begin
            if (ex2mem_exp || is_mem) begin
                exp_d = 1'b1;
            end else begin
                wr_reg_d    = ex2mem_wr_reg;
                wr_csrreg_d = ex2mem_wr_csrreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_reg_q      <= '0;
            wr_regindex_q <= '0;
            wr_wdata_q    <= '0;
            rd_is_x1_q    <= '0;
            rd_is_xn_q    <= '0;
            wr_csrreg_q   <= '0;
            wr_csrindex_q <= '0;
            wr_csrwdata_q <= '0;
            exp_q         <= '0;
        end else begin
            state_q       <= state_d;
            wr_reg_q      <= wr_reg_d;
            wr_regindex_q <= wr_regindex_d;
            wr_wdata_q    <= wr_wdata_d;
            rd_is_x1_q    <= rd_is_x1_d;
            rd_is_xn_q    <= rd_is_xn_d;
            wr_csrreg_q   <= wr_csrreg_d;
            wr_csrindex_q <= wr_csrindex_d;
            wr_csrwdata_q <= wr_csrwdata_d;
            exp_q         <= exp_d;
        end
    end

    assign mem2wb_wr_reg_ffout      = wr_reg_q;
    assign mem2wb_wr_regindex_ffout = wr_regindex_q;
    assign mem2wb_wr_wdata_ffout    = wr_wdata_q;
    assign mem2wb_rd_is_x1_ffout    = rd_is_x1_q;
    assign mem2wb_rd_is_xn_ffout    = rd_is_xn_q;
    assign mem2wb_wr_csrreg_ffout   = wr_csrreg_q;
    assign mem2wb_wr_csrindex_ffout = wr_csrindex_q;
    assign mem2wb_wr_csrwdata_ffout = wr_csrwdata_q;
    assign mem2wb_exp_ffout         = exp_q;

endmodule

// File: tb/tb_inst_mem_stage.sv
// Scoreboard bench for inst_mem_stage: a driver issues instructions and pushes
// expected write-back results; a monitor pops them when the stage retires one.
module tb_inst_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex2mem_valid, ex2mem_memrd, ex2mem_memwr;
    logic [2:0]  ex2mem_funct3;
    logic [31:0] ex2mem_memaddr, ex2mem_memwdata, ex2mem_wr_wdata, ex2mem_wr_csrwdata;
    logic        ex2mem_wr_reg, ex2mem_wr_csrreg, ex2mem_exp;
    logic [4:0]  ex2mem_wr_regindex;
    logic [11:0] ex2mem_wr_csrindex;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, mem_stall;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        o_wr_reg, o_x1, o_xn, o_csrreg, o_exp;
    logic [4:0]  o_idx;
    logic [31:0] o_wdata, o_cdata;
    logic [11:0] o_cidx;

    inst_mem_stage #(.AW(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex2mem_valid(ex2mem_valid), .ex2mem_memrd(ex2mem_memrd), .ex2mem_memwr(ex2mem_memwr),
        .ex2mem_funct3(ex2mem_funct3), .ex2mem_memaddr(ex2mem_memaddr),
        .ex2mem_memwdata(ex2mem_memwdata), .ex2mem_wr_reg(ex2mem_wr_reg),
        .ex2mem_wr_regindex(ex2mem_wr_regindex), .ex2mem_wr_wdata(ex2mem_wr_wdata),
        .ex2mem_wr_csrreg(ex2mem_wr_csrreg), .ex2mem_wr_csrindex(ex2mem_wr_csrindex),
        .ex2mem_wr_csrwdata(ex2mem_wr_csrwdata), .ex2mem_exp(ex2mem_exp),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
        .mem2wb_wr_reg_ffout(o_wr_reg), .mem2wb_wr_regindex_ffout(o_idx),
        .mem2wb_wr_wdata_ffout(o_wdata), .mem2wb_rd_is_x1_ffout(o_x1),
        .mem2wb_rd_is_xn_ffout(o_xn), .mem2wb_wr_csrreg_ffout(o_csrreg),
        .mem2wb_wr_csrindex_ffout(o_cidx), .mem2wb_wr_csrwdata_ffout(o_cdata),
        .mem2wb_exp_ffout(o_exp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic        wreg;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic        csr;
        logic [11:0] cidx;
        logic [31:0] cdata;
        logic        exp;
    } ins_t;

    typedef struct packed {
        logic        full;
        logic        wr_reg;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic        x1, xn, csr;
        logic [11:0] cidx;
        logic [31:0] cdata;
        logic        exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int unsigned u;
        int          s;
        u = rdata / (2 ** ((addr % 4) * 8));
        case (f3)
            3'b000: begin s = int'(u % 256);   if (s >= 128)   s -= 256;   return 32'(s); end
            3'b001: begin s = int'(u % 65536); if (s >= 32768) s -= 65536; return 32'(s); end
            3'b100: return u % 256;
            3'b101: return u % 65536;
            default: return u;
        endcase
    endfunction

    function automatic exp_t model(input ins_t t, input logic [31:0] rdata);
        exp_t e;
        bit   mis;
        mis     = (t.rd || t.wr) && (t.addr % acc_size(t.f3) != 0);
        e.idx   = t.idx;
        e.x1    = (t.idx == 1);
        e.xn    = (t.idx != 0);
        e.cidx  = t.cidx;
        e.cdata = t.cdata;
        e.wdata = t.wdata;
        e.full  = 1'b1;
        e.exp   = 1'b0;
        e.wr_reg = t.wreg;
        e.csr   = t.csr;
        if (t.exp || mis) begin
            e.full = 1'b0; e.wr_reg = 1'b0; e.csr = 1'b0; e.exp = 1'b1;
        end else if (t.wr) begin
            e.full = 1'b0; e.wr_reg = 1'b0;
        end else if (t.rd) begin
            e.wdata = load_val(t.f3, t.addr, rdata);
        end
        return e;
    endfunction

    task automatic drive(input ins_t t);
        ex2mem_memrd = t.rd;       ex2mem_memwr = t.wr;        ex2mem_funct3 = t.f3;
        ex2mem_memaddr = t.addr;   ex2mem_memwdata = t.sdata;  ex2mem_wr_reg = t.wreg;
        ex2mem_wr_regindex = t.idx; ex2mem_wr_wdata = t.wdata; ex2mem_wr_csrreg = t.csr;
        ex2mem_wr_csrindex = t.cidx; ex2mem_wr_csrwdata = t.cdata; ex2mem_exp = t.exp;
    endtask

    // Entered and left at posedge+1; gd = cycles before gnt, rd = cycles from gnt to rvalid (>=1).
    task automatic issue(input ins_t t, input int gd, input int rd, input logic [31:0] rdata);
        bit          legal;
        int          last;
        int unsigned off, sz;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        sz    = acc_size(t.f3);
        off   = t.addr % 4;
        legal = (t.rd || t.wr) && !t.exp && (t.addr % sz == 0);
        ebe   = t.wr ? 4'((2 ** sz - 1) * (2 ** off)) : 4'hF;
        ewd   = (sz == 1) ? (t.sdata % 256) * 32'h01010101 :
                (sz == 2) ? (t.sdata % 65536) * 32'h00010001 : t.sdata;
        drive(t);
        ex2mem_valid = 1'b1;
        sb_q.push_back(model(t, rdata));
        last = legal ? gd + rd : 0;
        for (int k = 0; k <= last; k++) begin
            dbus_gnt    = legal && (k == gd);
            dbus_rvalid = legal && (k == last);
            dbus_rdata  = (legal && k == last) ? rdata : $urandom;
            @(negedge clk);
            chk("mem_stall", mem_stall, legal && k != last);
            chk("dbus_req", dbus_req, legal && k <= gd);
            if (legal && k <= gd) begin
                chk("dbus_addr", dbus_addr, t.addr - off);
                chk("dbus_be", dbus_be, ebe);
                chk("dbus_we", dbus_we, t.wr);
                if (t.wr) chk("dbus_wdata", dbus_wdata, ewd);
            end
            @(posedge clk); #1;
        end
        ex2mem_valid = 1'b0;
        dbus_gnt     = 1'b0;
        dbus_rvalid  = 1'b0;
    endtask

    // Monitor: 0 = bubble expected, 1 = retirement, 2 = reset, 3 = nothing yet.
    int prev_kind = 3;
    always @(negedge clk) begin
        exp_t e;
        if (prev_kind == 2) begin
            chk("rst_wr_reg", o_wr_reg, 0);   chk("rst_idx", o_idx, 0);
            chk("rst_wdata", o_wdata, 0);     chk("rst_x1", o_x1, 0);
            chk("rst_xn", o_xn, 0);           chk("rst_csrreg", o_csrreg, 0);
            chk("rst_cidx", o_cidx, 0);       chk("rst_cdata", o_cdata, 0);
            chk("rst_exp", o_exp, 0);
        end else if (prev_kind == 1) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: retirement with empty scoreboard at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("wb_wr_reg", o_wr_reg, e.wr_reg);
                chk("wb_csrreg", o_csrreg, e.csr);
                chk("wb_exp", o_exp, e.exp);
                if (e.full) begin
                    chk("wb_idx", o_idx, e.idx);     chk("wb_wdata", o_wdata, e.wdata);
                    chk("wb_x1", o_x1, e.x1);        chk("wb_xn", o_xn, e.xn);
                    chk("wb_cidx", o_cidx, e.cidx);  chk("wb_cdata", o_cdata, e.cdata);
                end
            end
        end else if (prev_kind == 0) begin
            chk("bubble_wr_reg", o_wr_reg, 0);
            chk("bubble_csrreg", o_csrreg, 0);
            chk("bubble_exp", o_exp, 0);
        end
        prev_kind = rst ? 2 : (ex2mem_valid && !mem_stall) ? 1 : 0;
    end

    function automatic ins_t alu(input logic [4:0] idx, input logic [31:0] wd);
        ins_t t = '0;
        t.wreg = 1'b1; t.idx = idx; t.wdata = wd;
        t.cidx = 12'h300; t.cdata = 32'h55AA;
        return t;
    endfunction

    function automatic ins_t memop(input bit is_ld, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] sd, input logic [4:0] idx);
        ins_t t = '0;
        t.rd = is_ld; t.wr = !is_ld; t.f3 = f3; t.addr = a; t.sdata = sd;
        t.wreg = 1'b1; t.idx = idx; t.wdata = 32'hDEAD0000;
        return t;
    endfunction

    initial begin
        ins_t t;
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst = 1'b1;
        drive('0);
        ex2mem_valid = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dbus_req", dbus_req, 0); chk("rst_dbus_we", dbus_we, 0);
        chk("rst_dbus_be", dbus_be, 0);   chk("rst_mem_stall", mem_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(alu(5'd5, 32'h1234), 0, 0, 0);
        issue(memop(1, 3'b000, 32'h1003, 0, 5'd7), 0, 2, 32'h80FFFFFF);
        issue(memop(1, 3'b100, 32'h1003, 0, 5'd7), 0, 2, 32'h80FFFFFF);
        issue(memop(0, 3'b001, 32'h2002, 32'hABCD, 5'd9), 3, 1, 0);
        issue(memop(1, 3'b010, 32'h1001, 0, 5'd3), 0, 1, 0);
        t = memop(1, 3'b010, 32'h1000, 0, 5'd4); t.exp = 1'b1;
        issue(t, 0, 1, 0);
        issue(alu(5'd1, 32'hCAFEF00D), 0, 0, 0);

        // Reset while a load waits for its response; the late rvalid must be dropped.
        drive(memop(1, 3'b010, 32'h3000, 0, 5'd6));
        ex2mem_valid = 1'b1; dbus_gnt = 1'b1;
        @(negedge clk); chk("midrst_req", dbus_req, 1);
        @(posedge clk); #1; dbus_gnt = 1'b0;
        @(negedge clk); chk("midrst_wait_stall", mem_stall, 1); chk("midrst_wait_req", dbus_req, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("midrst_stall", mem_stall, 0); chk("midrst_dreq", dbus_req, 0);
        chk("midrst_be", dbus_be, 0); chk("midrst_we", dbus_we, 0);
        @(posedge clk); #1; rst = 1'b0; ex2mem_valid = 1'b0;
        @(negedge clk); chk("postrst_stall", mem_stall, 0);
        @(posedge clk); #1; dbus_rvalid = 1'b1; dbus_rdata = 32'h12345678;
        @(negedge clk); chk("stray_rvalid_stall", mem_stall, 0); chk("stray_rvalid_req", dbus_req, 0);
        @(posedge clk); #1; dbus_rvalid = 1'b0;
        issue(alu(5'd0, 32'h0BADF00D), 0, 0, 0);

        for (int n = 0; n < 250; n++) begin
            int kind = $urandom_range(0, 2);
            t = '0;
            t.idx = 5'($urandom); t.wreg = 1'($urandom); t.wdata = $urandom;
            t.cidx = 12'($urandom); t.cdata = $urandom; t.sdata = $urandom;
            t.addr = $urandom; t.exp = ($urandom_range(0, 9) == 0);
            if (kind == 0) begin
                t.csr = 1'($urandom);
            end else if (kind == 1) begin
                t.rd = 1'b1; t.f3 = ld_f3[$urandom_range(0, 4)];
            end else begin
                t.wr = 1'b1; t.f3 = 3'($urandom_range(0, 2));
            end
            issue(t, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                dbus_rvalid = 1'($urandom);
                dbus_rdata  = $urandom;
                @(posedge clk); #1;
            end
            dbus_rvalid = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
